revo_word_tracker: RTL

REVO_WORD_TRACKER -- requirements
Module: revo_word_tracker

---
 rtl/revo_pkg.sv | 31 +++
 rtl/revo_marker_decoder.sv | 31 +++
 rtl/revo_word_tracker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/revo_pkg.sv
// Shared definitions for the revolution word tracker: FSM encoding, default
// revolution length, the all-ones marker word and the leading-zero helper.
package revo_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam int         DEFAULT_NUMBER_OF_QUAD_BUNCHES = 1280;
  localparam logic [7:0] MARKER_WORD                    = 8'hFF;

  // An all-zero word yields 7; callers qualify with word != 0.
  function automatic logic [2:0] leading_zeros(input logic [7:0] word);
    logic [2:0] count;
    logic       found;
    count = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (!found && !word[i]) begin
        count = count + 3'd1;
      end else begin
        found = 1'b1;
      end
    end
    return count;
  endfunction

endpackage

// File: rtl/revo_marker_decoder.sv
// Two-stage input register plus combinational marker decode: a marker is a
// zero word followed by a right-aligned run of ones (the marker word shifted).
module revo_marker_decoder
  import revo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] word_in,
  output logic       marker,
  output logic [2:0] marker_phase
);

  logic [7:0] word_q;
  logic [7:0] word_q2;

  // Input pipeline: word_q is the current word, word_q2 the one before it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q  <= 8'd0;
      word_q2 <= 8'd0;
    end else begin
      word_q  <= word_in;
      word_q2 <= word_q;
    end
  end

  assign marker_phase = leading_zeros(word_q);
  assign marker       = (word_q2 == 8'd0) && (word_q != 8'd0) &&
                        (word_q == (MARKER_WORD >> marker_phase));

endmodule

// File: rtl/revo_word_tracker.sv
// Revolution marker tracker with flywheel counter and lock FSM.
// Optional macro REVO_TRACKER_ERROR_COUNTERS_EN builds the early/missing counters.
module revo_word_tracker
  import revo_pkg::*;
#(
  parameter int NUMBER_OF_QUAD_BUNCHES = DEFAULT_NUMBER_OF_QUAD_BUNCHES,
  parameter int LOCK_COUNT             = 3,
  parameter int LOSS_COUNT             = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  word_in,
  output logic        revo,
  output logic [2:0]  bit_phase,
  output logic [10:0] quad_bunch_counter,
  output logic        locked,
  output logic [7:0]  early_count,
  output logic [7:0]  missing_count
);

  localparam logic [10:0] LAST_POSITION = 11'(NUMBER_OF_QUAD_BUNCHES - 1);
  localparam logic [7:0]  LOCK_TARGET   = 8'(LOCK_COUNT);
  localparam logic [7:0]  LOSS_TARGET   = 8'(LOSS_COUNT);

  logic       marker;
  logic [2:0] marker_phase;
  logic       marker_r;
  logic [2:0] phase_r;

  state_t      state, state_next;
  logic [10:0] counter_next, counter_wrap;
  logic [2:0]  phase_next;
  logic [7:0]  good, good_next;
  logic [7:0]  bad_run, bad_next;
  logic        at_end, hit, early, missing;

  revo_marker_decoder u_decoder (
    .clock        (clock),
    .reset        (reset),
    .word_in      (word_in),
    .marker       (marker),
    .marker_phase (marker_phase)
  );

  assign at_end       = (quad_bunch_counter == LAST_POSITION);
  assign counter_wrap = at_end ? 11'd0 : quad_bunch_counter + 11'd1;
  assign hit          = marker_r && at_end && (phase_r == bit_phase);
  assign early        = marker_r && !hit;
  assign missing      = at_end && !marker_r;

  // Next-state logic; the counter free-runs outside SEARCH and is never pulled by early markers.
  always_comb begin
    state_next   = state;
    counter_next = quad_bunch_counter;
    phase_next   = bit_phase;
    good_next    = good;
    bad_next     = bad_run;
    case (state)
      SEARCH: begin
        counter_next = 11'd0;
        if (marker_r) begin
          state_next = VERIFY;
          phase_next = phase_r;
          good_next  = 8'd1;
          bad_next   = 8'd0;
        end else begin
          state_next = SEARCH;
        end
      end
      VERIFY: begin
        counter_next = counter_wrap;
        if (hit) begin
          good_next = good + 8'd1;
          if ((good + 8'd1) >= LOCK_TARGET) begin
            state_next = LOCKED;
            bad_next   = 8'd0;
          end else begin
            state_next = VERIFY;
          end
        end else if (early || missing) begin
          state_next   = SEARCH;
          counter_next = 11'd0;
          good_next    = 8'd0;
        end else begin
          state_next = VERIFY;
        end
      end
      LOCKED: begin
        counter_next = counter_wrap;
        if (hit) begin
          bad_next = 8'd0;
        end else if (early || missing) begin
          bad_next = bad_run + 8'd1;
          if ((bad_run + 8'd1) >= LOSS_TARGET) begin
            state_next = DROP;
          end else begin
            state_next = LOCKED;
          end
        end else begin
          state_next = LOCKED;
        end
      end
      DROP: begin
        state_next   = SEARCH;
        counter_next = 11'd0;
        good_next    = 8'd0;
        bad_next     = 8'd0;
      end
      default: begin
        state_next   = SEARCH;
        counter_next = 11'd0;
        good_next    = 8'd0;
        bad_next     = 8'd0;
      end
    endcase
  end

  // State, decode pipeline and registered outputs (revo/locked from next-state values).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= SEARCH;
      marker_r           <= 1'b0;
      phase_r            <= 3'd0;
      good               <= 8'd0;
      bad_run            <= 8'd0;
      quad_bunch_counter <= 11'd0;
      bit_phase          <= 3'd0;
      revo               <= 1'b0;
      locked             <= 1'b0;
    end else begin
      state              <= state_next;
      marker_r           <= marker;
      phase_r            <= marker_phase;
      good               <= good_next;
      bad_run            <= bad_next;
      quad_bunch_counter <= counter_next;
      bit_phase          <= phase_next;
      revo               <= (state_next == LOCKED) && (counter_next == 11'd0);
      locked             <= (state_next == LOCKED);
    end
  end

`ifdef REVO_TRACKER_ERROR_COUNTERS_EN
  logic count_early, count_missing;
  assign count_early   = (state == LOCKED) && early;
  assign count_missing = (state == LOCKED) && missing;

  // Saturating error counters, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      early_count   <= 8'd0;
      missing_count <= 8'd0;
    end else begin
      if (count_early && (early_count != 8'hFF)) begin
        early_count <= early_count + 8'd1;
      end
      if (count_missing && (missing_count != 8'hFF)) begin
        missing_count <= missing_count + 8'd1;
      end
    end
  end
`else
  assign early_count   = 8'd0;
  assign missing_count = 8'd0;
`endif

endmodule
